// File: rtl/bcd_pkg.sv
// Shared encodings and constants for the BCD/binary conversion stages.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] CORR          = 4'd3;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_sub3_if_ge8.sv
// Digit correction cell: y = a-3 when a >= 8, else a; combinational, zero latency.
// No handshake; output follows input.
module sub3_if_ge8
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);

  // Subtraction as two's-complement addition of -3 (4'b1101), carry-out dropped.
  localparam logic [3:0] NEG_CORR = ~CORR + 4'd1;

  logic [3:0] sum;
  logic [3:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i] = a[i] ^ NEG_CORR[i] ^ carry[i];
    if (i < 3) begin : g_carry
      assign carry[i+1] = (a[i] & NEG_CORR[i]) | (carry[i] & (a[i] ^ NEG_CORR[i]));
    end
  end

  // a >= 8 is exactly the MSB being set.
  assign y = a[3] ? sum : a;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Reverse double-dabble BCD-to-binary converter; done BIN_W+1 cycles after accept (1 on bad digit).
// start is taken only in IDLE; requests while busy are dropped, not queued.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIGITS*4-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BIN_W-1:0]   bin_sh;
  logic               in_bad;

  assign {bcd_sh, bin_sh} = {bcd_reg, bin_reg} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    sub3_if_ge8 u_sub3 (
      .a (bcd_sh[g*4 +: 4]),
      .y (bcd_corr[g*4 +: 4])
    );
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(bcd_in[i*4 +: 4])) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            if (in_bad) begin
              // Malformed input skips the shift loop and reports immediately.
              state   <= ST_DONE;
              done    <= 1'b1;
              bin_out <= '0;
              err     <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          bcd_reg <= bcd_corr;
          bin_reg <= bin_sh;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bin_out <= bin_sh;
            err     <= 1'b0;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
